// File: rtl/next_pc_logic_if.sv
// -----------------------------------------------------------------------------
// next_pc_logic_if
// Bundles the PC-selection signals between the control/ALU side and the
// next-PC block.
//   CurrentPC    [63:0] address of the instruction now executing
//   SignExtImm64 [63:0] sign-extended branch offset in words
//   Branch              conditional branch flag
//   Uncondbranch        unconditional branch flag
//   ALUZero             ALU zero flag
//   NextPC       [63:0] combinational next address
//   BranchTaken         1 when NextPC is the branch target
//   PCReg        [63:0] registered NextPC
// master: drives the instruction-side inputs and observes the results.
// slave : the next-PC block itself.
// -----------------------------------------------------------------------------
interface next_pc_logic_if;
  logic        [63:0] CurrentPC;
  logic signed [63:0] SignExtImm64;
  logic               Branch;
  logic               Uncondbranch;
  logic               ALUZero;
  logic        [63:0] NextPC;
  logic               BranchTaken;
  logic        [63:0] PCReg;

  modport master (
    output CurrentPC, SignExtImm64, Branch, Uncondbranch, ALUZero,
    input  NextPC, BranchTaken, PCReg
  );

  modport slave (
    input  CurrentPC, SignExtImm64, Branch, Uncondbranch, ALUZero,
    output NextPC, BranchTaken, PCReg
  );
endinterface

// File: rtl/next_pc_logic.sv
// -----------------------------------------------------------------------------
// next_pc_logic
// Selects the next program counter for the 64-bit single-cycle datapath:
// either the sequential address (PC + 4) or the branch target
// (PC + offset * 4), and keeps a registered copy for the fetch stage.
// Ports:
//   CLK      rising-edge clock for the PC register
//   Reset_L  synchronous active-low reset (clears PCReg only)
//   bus      next_pc_logic_if.slave (see interface header for signals)
// NextPC and BranchTaken are purely combinational; PCReg lags by one edge.
// -----------------------------------------------------------------------------
module next_pc_logic (
  input  logic          CLK,
  input  logic          Reset_L,
  next_pc_logic_if.slave bus
);

  logic [63:0] w_seq_pc;
  logic [63:0] w_offset_bytes;
  logic [63:0] w_branch_target;
  logic [63:0] w_next_pc;
  logic        w_taken;
  logic [63:0] r_pc;

  // Word offset to byte offset; bits [63:62] fall off the top, and
  // two's-complement addition handles negative offsets with no special case.
  assign w_offset_bytes  = {bus.SignExtImm64[61:0], 2'b00};

  // All adds wrap modulo 2^64; carry-out is deliberately dropped.
  assign w_seq_pc        = bus.CurrentPC + 64'd4;
  assign w_branch_target = bus.CurrentPC + w_offset_bytes;

  // Unconditional branches also rely on ALUZero: the ALU path forces it
  // high for B-type instructions, so it is not overridden here.
  assign w_taken   = (bus.Branch | bus.Uncondbranch) & bus.ALUZero;
  assign w_next_pc = w_taken ? w_branch_target : w_seq_pc;

  always_ff @(posedge CLK) begin
    if (!Reset_L) r_pc <= 64'd0;
    else          r_pc <= w_next_pc;
  end

  assign bus.NextPC      = w_next_pc;
  assign bus.BranchTaken = w_taken;
  assign bus.PCReg       = r_pc;

endmodule

// File: tb/tb_next_pc_logic.sv
module tb_next_pc_logic;

  logic CLK;
  logic Reset_L;
  int   n_checks;
  int   n_errors;

  next_pc_logic_if bus ();

  next_pc_logic dut (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] pc, input logic [63:0] imm,
                       input logic br, input logic ub, input logic z);
    bus.CurrentPC    = pc;
    bus.SignExtImm64 = imm;
    bus.Branch       = br;
    bus.Uncondbranch = ub;
    bus.ALUZero      = z;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset_L  = 1'b0;
    drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Reset held for two edges
    tick();
    tick();
    chk("reset_pcreg", bus.PCReg, 64'd0);

    // Combinational vectors (independent of reset)
    drive(64'd0, 64'd2, 1'b0, 1'b0, 1'b0);
    chk("seq_nextpc", bus.NextPC, 64'd4);
    chk("seq_taken", {63'd0, bus.BranchTaken}, 64'd0);
    drive(64'd0, 64'd2, 1'b0, 1'b0, 1'b1);
    chk("zero_only", bus.NextPC, 64'd4);
    drive(64'd0, 64'd2, 1'b0, 1'b1, 1'b0);
    chk("ub_z0", bus.NextPC, 64'd4);
    chk("ub_z0_taken", {63'd0, bus.BranchTaken}, 64'd0);
    drive(64'd0, 64'd2, 1'b0, 1'b1, 1'b1);
    chk("ub_z1", bus.NextPC, 64'd8);
    chk("ub_z1_taken", {63'd0, bus.BranchTaken}, 64'd1);
    drive(64'd0, 64'd2, 1'b1, 1'b0, 1'b0);
    chk("br_z0", bus.NextPC, 64'd4);
    drive(64'd0, 64'd2, 1'b1, 1'b0, 1'b1);
    chk("br_z1", bus.NextPC, 64'd8);
    chk("br_z1_taken", {63'd0, bus.BranchTaken}, 64'd1);
    drive(64'd0, 64'd2, 1'b1, 1'b1, 1'b0);
    chk("both_z0", bus.NextPC, 64'd4);
    drive(64'd0, 64'd2, 1'b1, 1'b1, 1'b1);
    chk("both_z1", bus.NextPC, 64'd8);
    drive(64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b1);
    chk("neg_offset", bus.NextPC, 64'hF0);
    drive(64'hFFFF_FFFF_FFFF_FFFC, 64'd7, 1'b0, 1'b0, 1'b0);
    chk("seq_wrap", bus.NextPC, 64'd0);
    drive(64'd0, 64'h4000_0000_0000_0001, 1'b1, 1'b0, 1'b1);
    chk("imm_top_drop", bus.NextPC, 64'd4);
    drive(64'h1003, 64'd1, 1'b0, 1'b0, 1'b0);
    chk("unaligned_seq", bus.NextPC, 64'h1007);
    chk("pcreg_in_reset", bus.PCReg, 64'd0);

    // Release reset, sequential load
    drive(64'h20, 64'd0, 1'b0, 1'b0, 1'b0);
    Reset_L = 1'b1;
    tick();
    chk("pcreg_load", bus.PCReg, 64'h24);

    // Branch-taken load
    drive(64'h40, 64'd3, 1'b0, 1'b1, 1'b1);
    tick();
    chk("pcreg_branch", bus.PCReg, 64'h4C);

    // Mid-run reset
    drive(64'h20, 64'd0, 1'b0, 1'b0, 1'b0);
    Reset_L = 1'b0;
    tick();
    chk("midrun_reset_pcreg", bus.PCReg, 64'd0);
    chk("midrun_reset_nextpc", bus.NextPC, 64'h24);
    chk("midrun_reset_taken", {63'd0, bus.BranchTaken}, 64'd0);

    // First post-reset edge loads NextPC
    Reset_L = 1'b1;
    tick();
    chk("post_reset_load", bus.PCReg, 64'h24);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
